// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the F/D/E/W core: pending-write scoreboard for multi-cycle
// results, counted load-use stalls, two forwarding sources and saturating perf counters.
module hazard_scoreboard_unit #(
   parameter int unsigned REG_AW             = 3,
   parameter bit          ZERO_REG_HARDWIRED = 1'b1,
   parameter int unsigned LOAD_USE_STALL     = 1,
   parameter int unsigned CNT_W              = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_D,
   input  logic [REG_AW-1:0]        rs1_D,
   input  logic [REG_AW-1:0]        rs2_D,
   input  logic                     rs1_used_D,
   input  logic                     rs2_used_D,
   input  logic [REG_AW-1:0]        rd_D,
   input  logic                     reg_write_D,
   input  logic                     mc_op_D,
   input  logic                     jump_D,
   input  logic [REG_AW-1:0]        rs1_E,
   input  logic [REG_AW-1:0]        rs2_E,
   input  logic [REG_AW-1:0]        rd_E,
   input  logic                     reg_write_E,
   input  logic                     mem_read_E,
   input  logic                     branch_taken_E,
   input  logic [REG_AW-1:0]        rd_W,
   input  logic                     reg_write_W,
   input  logic                     mc_busy,
   input  logic                     mc_wb_valid,
   input  logic [REG_AW-1:0]        mc_wb_rd,
   input  logic                     perf_clr,
   output logic                     stall_F,
   output logic                     stall_D,
   output logic                     flush_F,
   output logic                     flush_D,
   output logic [1:0]               forward_A,
   output logic [1:0]               forward_B,
   output logic [(2**REG_AW)-1:0]   pending_mask,
   output logic [CNT_W-1:0]         stall_cycles,
   output logic [CNT_W-1:0]         flush_cycles
);

   localparam int unsigned NUM_REGS = 2**REG_AW;
   localparam logic [2:0]  LUC_LOAD = 3'(LOAD_USE_STALL - 1);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] wb_clr_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] pend_eff;
   logic [2:0]          luc;
   logic                load_use;
   logic                sb_raw;
   logic                sb_waw;
   logic                struct_haz;
   logic                stall_req;

   function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return (a == b) && (!ZERO_REG_HARDWIRED || (a != '0));
   endfunction

   always_comb begin
      forward_A = 2'b00;
      if (reg_write_W && reg_match(rd_W, rs1_E))
         forward_A = 2'b10;
      else if (mc_wb_valid && reg_match(mc_wb_rd, rs1_E))
         forward_A = 2'b01;
   end

   always_comb begin
      forward_B = 2'b00;
      if (reg_write_W && reg_match(rd_W, rs2_E))
         forward_B = 2'b10;
      else if (mc_wb_valid && reg_match(mc_wb_rd, rs2_E))
         forward_B = 2'b01;
   end

   always_comb begin
      wb_clr_mask = '0;
      if (mc_wb_valid)
         wb_clr_mask[mc_wb_rd] = 1'b1;
   end

   // A result written back this cycle no longer blocks its readers.
   assign pend_eff = pending & ~wb_clr_mask;

   assign load_use   = valid_D && mem_read_E && reg_write_E &&
                       ((rs1_used_D && reg_match(rd_E, rs1_D)) ||
                        (rs2_used_D && reg_match(rd_E, rs2_D)));
   assign sb_raw     = valid_D && ((rs1_used_D && pend_eff[rs1_D]) ||
                                   (rs2_used_D && pend_eff[rs2_D]));
   assign sb_waw     = valid_D && reg_write_D && pend_eff[rd_D];
   assign struct_haz = valid_D && mc_op_D && mc_busy;
   assign stall_req  = load_use || (luc != 3'd0) || sb_raw || sb_waw || struct_haz;

   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      flush_F = 1'b0;
      flush_D = 1'b0;
      if (branch_taken_E) begin
         flush_F = 1'b1;
         flush_D = 1'b1;
      end else if (stall_req) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         flush_D = 1'b1;
      end else if (jump_D) begin
         flush_F = 1'b1;
      end
   end

   always_comb begin
      set_mask = '0;
      if (valid_D && mc_op_D && reg_write_D && !stall_D && !branch_taken_E &&
          !(ZERO_REG_HARDWIRED && (rd_D == '0)))
         set_mask[rd_D] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         luc     <= 3'd0;
      end else begin
         pending <= (pending & ~wb_clr_mask) | set_mask;
         if (branch_taken_E)
            luc <= 3'd0;
         else if (luc != 3'd0)
            luc <= luc - 3'd1;
         else if (load_use)
            luc <= LUC_LOAD;
      end
   end

   assign pending_mask = pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else if (perf_clr) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (stall_D && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_D && !stall_D && (flush_cycles != '1))
            flush_cycles <= flush_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_hazard_scoreboard_unit;

   localparam int REG_AW   = 3;
   localparam int NUM_REGS = 8;
   localparam int LUS      = 3;
   localparam int CNT_W    = 8;
   localparam int CNT_MAX  = 255;

   logic clk = 1'b0;
   logic rst_n;
   logic valid_D, rs1_used_D, rs2_used_D, reg_write_D, mc_op_D, jump_D;
   logic [REG_AW-1:0] rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_W, mc_wb_rd;
   logic reg_write_E, mem_read_E, branch_taken_E, reg_write_W;
   logic mc_busy, mc_wb_valid, perf_clr;
   logic stall_F, stall_D, flush_F, flush_D;
   logic [1:0] forward_A, forward_B;
   logic [NUM_REGS-1:0] pending_mask;
   logic [CNT_W-1:0] stall_cycles, flush_cycles;

   hazard_scoreboard_unit #(
      .REG_AW(REG_AW), .ZERO_REG_HARDWIRED(1'b1), .LOAD_USE_STALL(LUS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
      .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_D(rd_D),
      .reg_write_D(reg_write_D), .mc_op_D(mc_op_D), .jump_D(jump_D),
      .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
      .mem_read_E(mem_read_E), .branch_taken_E(branch_taken_E), .rd_W(rd_W),
      .reg_write_W(reg_write_W), .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid),
      .mc_wb_rd(mc_wb_rd), .perf_clr(perf_clr), .stall_F(stall_F), .stall_D(stall_D),
      .flush_F(flush_F), .flush_D(flush_D), .forward_A(forward_A), .forward_B(forward_B),
      .pending_mask(pending_mask), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_pend [NUM_REGS];
   int m_rem = 0;
   int m_sc  = 0;
   int m_fc  = 0;

   typedef struct {
      bit sF, sD, fF, fD, lu;
      int fa, fb;
   } exp_t;

   function automatic bit mt(input int a, input int b);
      return (a == b) && (a != 0);
   endfunction

   function automatic int fwd(input int rs);
      if (reg_write_W && mt(int'(rd_W), rs)) return 2;
      if (mc_wb_valid && mt(int'(mc_wb_rd), rs)) return 1;
      return 0;
   endfunction

   function automatic bit busy_reg(input int r);
      return m_pend[r] && !(mc_wb_valid && int'(mc_wb_rd) == r);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit hazard;
      e = '{default: 0};
      e.fa = fwd(int'(rs1_E));
      e.fb = fwd(int'(rs2_E));
      e.lu = valid_D && mem_read_E && reg_write_E &&
             ((rs1_used_D && mt(int'(rd_E), int'(rs1_D))) ||
              (rs2_used_D && mt(int'(rd_E), int'(rs2_D))));
      hazard = e.lu || (m_rem > 0) ||
               (valid_D && ((rs1_used_D && busy_reg(int'(rs1_D))) ||
                            (rs2_used_D && busy_reg(int'(rs2_D))) ||
                            (reg_write_D && busy_reg(int'(rd_D))) ||
                            (mc_op_D && mc_busy)));
      if (branch_taken_E) begin
         e.fF = 1; e.fD = 1;
      end else if (hazard) begin
         e.sF = 1; e.sD = 1; e.fD = 1;
      end else if (jump_D) begin
         e.fF = 1;
      end
      return e;
   endfunction

   exp_t e_now;
   bit   n_pend [NUM_REGS];
   int   n_rem, n_sc, n_fc;

   always_comb begin
      e_now  = model_out();
      n_pend = m_pend;
      if (mc_wb_valid) n_pend[int'(mc_wb_rd)] = 0;
      if (valid_D && mc_op_D && reg_write_D && !e_now.sD && !branch_taken_E && rd_D != 0)
         n_pend[int'(rd_D)] = 1;
      n_rem = m_rem;
      if (branch_taken_E) n_rem = 0;
      else if (m_rem > 0) n_rem = m_rem - 1;
      else if (e_now.lu) n_rem = LUS - 1;
      n_sc = m_sc;
      n_fc = m_fc;
      if (perf_clr) begin
         n_sc = 0; n_fc = 0;
      end else begin
         if (e_now.sD && m_sc < CNT_MAX) n_sc = m_sc + 1;
         if (e_now.fD && !e_now.sD && m_fc < CNT_MAX) n_fc = m_fc + 1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend <= '{default: 0};
         m_rem  <= 0;
         m_sc   <= 0;
         m_fc   <= 0;
      end else begin
         m_pend <= n_pend;
         m_rem  <= n_rem;
         m_sc   <= n_sc;
         m_fc   <= n_fc;
      end
   end

   // One compare process, sampling mid-cycle on the falling edge.
   always @(negedge clk) begin
      logic [NUM_REGS-1:0] pm;
      for (int r = 0; r < NUM_REGS; r++) pm[r] = m_pend[r];
      chk("m_stall_F", 32'(stall_F), 32'(e_now.sF));
      chk("m_stall_D", 32'(stall_D), 32'(e_now.sD));
      chk("m_flush_F", 32'(flush_F), 32'(e_now.fF));
      chk("m_flush_D", 32'(flush_D), 32'(e_now.fD));
      chk("m_forward_A", 32'(forward_A), 32'(e_now.fa));
      chk("m_forward_B", 32'(forward_B), 32'(e_now.fb));
      chk("m_pending_mask", 32'(pending_mask), 32'(pm));
      chk("m_stall_cycles", 32'(stall_cycles), 32'(m_sc));
      chk("m_flush_cycles", 32'(flush_cycles), 32'(m_fc));
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      valid_D = 0; rs1_D = 0; rs2_D = 0; rs1_used_D = 0; rs2_used_D = 0; rd_D = 0;
      reg_write_D = 0; mc_op_D = 0; jump_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0;
      reg_write_E = 0; mem_read_E = 0; branch_taken_E = 0; rd_W = 0; reg_write_W = 0;
      mc_busy = 0; mc_wb_valid = 0; mc_wb_rd = 0; perf_clr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use_x2();
      valid_D = 1; rs2_D = 3'd2; rs2_used_D = 1;
      mem_read_E = 1; reg_write_E = 1; rd_E = 3'd2;
   endtask

   initial begin
      rst_n = 0;
      idle();
      #2;
      chk("rst_stall_D", 32'(stall_D), 0);
      chk("rst_flush_F", 32'(flush_F), 0);
      chk("rst_pending", 32'(pending_mask), 0);
      chk("rst_stall_cycles", 32'(stall_cycles), 0);
      step();
      rst_n = 1;

      // forwarding
      step();
      reg_write_W = 1; rd_W = 3'd3; rs1_E = 3'd3; rs2_E = 3'd3; #1;
      chk("fwd_A_w", 32'(forward_A), 32'd2);
      chk("fwd_B_w", 32'(forward_B), 32'd2);
      rd_W = 3'd0; rs1_E = 3'd0; rs2_E = 3'd0; #1;
      chk("fwd_A_x0", 32'(forward_A), 32'd0);
      chk("fwd_B_x0", 32'(forward_B), 32'd0);
      step();
      rd_W = 3'd3; rs1_E = 3'd3; rs2_E = 3'd6; mc_wb_valid = 1; mc_wb_rd = 3'd6; #1;
      chk("fwd_A_wprio", 32'(forward_A), 32'd2);
      chk("fwd_B_mc", 32'(forward_B), 32'd1);
      step();
      idle();
      perf_clr = 1;
      step();
      perf_clr = 0;

      // load-use: three stall cycles
      load_use_x2(); #1;
      chk("lu_c1_stall_F", 32'(stall_F), 1);
      chk("lu_c1_stall_D", 32'(stall_D), 1);
      chk("lu_c1_flush_D", 32'(flush_D), 1);
      chk("lu_c1_flush_F", 32'(flush_F), 0);
      step();
      mem_read_E = 0; reg_write_E = 0; #1;
      chk("lu_c2_stall_D", 32'(stall_D), 1);
      step(); #1;
      chk("lu_c3_stall_D", 32'(stall_D), 1);
      step(); #1;
      chk("lu_c4_stall_D", 32'(stall_D), 0);
      chk("lu_stall_cycles", 32'(stall_cycles), 3);
      idle();

      // scoreboard RAW with writeback bypass
      step();
      valid_D = 1; mc_op_D = 1; reg_write_D = 1; rd_D = 3'd5; #1;
      chk("mc_issue_stall", 32'(stall_D), 0);
      step();
      chk("mc_pending5", 32'(pending_mask), 32'h20);
      mc_op_D = 0; reg_write_D = 0; rs1_D = 3'd5; rs1_used_D = 1; #1;
      chk("raw_stall1", 32'(stall_D), 1);
      step(); #1;
      chk("raw_stall2", 32'(stall_D), 1);
      mc_wb_valid = 1; mc_wb_rd = 3'd5; #1;
      chk("raw_bypass", 32'(stall_D), 0);
      step(); #1;
      chk("raw_cleared", 32'(pending_mask), 0);
      idle();

      // set and clear of the same register: set wins
      step();
      valid_D = 1; mc_op_D = 1; reg_write_D = 1; rd_D = 3'd4;
      step();
      chk("sc_pending4", 32'(pending_mask), 32'h10);
      mc_wb_valid = 1; mc_wb_rd = 3'd4; #1;
      chk("sc_waw_bypass", 32'(stall_D), 0);
      step(); #1;
      chk("sc_set_wins", 32'(pending_mask), 32'h10);
      idle(); mc_wb_valid = 1; mc_wb_rd = 3'd4;
      step();
      idle(); #1;
      chk("sc_cleared", 32'(pending_mask), 0);

      // branch during a load-use stall, then jump
      step();
      load_use_x2(); #1;
      chk("br_pre_stall", 32'(stall_D), 1);
      step();
      mem_read_E = 0; reg_write_E = 0; branch_taken_E = 1; #1;
      chk("br_flush_F", 32'(flush_F), 1);
      chk("br_flush_D", 32'(flush_D), 1);
      chk("br_stall_F", 32'(stall_F), 0);
      chk("br_stall_D", 32'(stall_D), 0);
      step();
      branch_taken_E = 0; #1;
      chk("br_after_stall", 32'(stall_D), 0);
      idle(); jump_D = 1; #1;
      chk("jmp_flush_F", 32'(flush_F), 1);
      chk("jmp_flush_D", 32'(flush_D), 0);
      valid_D = 1; mc_op_D = 1; mc_busy = 1; #1;
      chk("jmp_held_flush_F", 32'(flush_F), 0);
      chk("jmp_held_stall_D", 32'(stall_D), 1);
      step();
      idle();

      // counter saturation and clear priority
      perf_clr = 1;
      step();
      perf_clr = 0; valid_D = 1; mc_op_D = 1; mc_busy = 1;
      repeat (CNT_MAX + 6) step();
      #1;
      chk("sat_stall_cycles", 32'(stall_cycles), 32'(CNT_MAX));
      perf_clr = 1;
      step(); #1;
      chk("clr_stall_cycles", 32'(stall_cycles), 0);
      idle();

      // reset asserted mid-stall
      step();
      load_use_x2();
      step();
      mem_read_E = 0; reg_write_E = 0; #1;
      chk("rs_pre_stall", 32'(stall_D), 1);
      rst_n = 0; #1;
      chk("rs_stall_drop", 32'(stall_D), 0);
      step();
      rst_n = 1;
      idle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step();
         rst_n          = ($urandom_range(0, 299) != 0);
         valid_D        = ($urandom_range(0, 3) != 0);
         rs1_D          = 3'($urandom);
         rs2_D          = 3'($urandom);
         rs1_used_D     = 1'($urandom);
         rs2_used_D     = 1'($urandom);
         rd_D           = 3'($urandom);
         reg_write_D    = 1'($urandom);
         mc_op_D        = ($urandom_range(0, 2) == 0);
         jump_D         = ($urandom_range(0, 5) == 0);
         rs1_E          = 3'($urandom);
         rs2_E          = 3'($urandom);
         rd_E           = 3'($urandom);
         reg_write_E    = 1'($urandom);
         mem_read_E     = ($urandom_range(0, 3) == 0);
         branch_taken_E = ($urandom_range(0, 9) == 0);
         rd_W           = 3'($urandom);
         reg_write_W    = 1'($urandom);
         mc_busy        = ($urandom_range(0, 3) == 0);
         mc_wb_valid    = ($urandom_range(0, 2) == 0);
         mc_wb_rd       = 3'($urandom);
         perf_clr       = ($urandom_range(0, 99) == 0);
      end
      step();
      idle();
      rst_n = 1;
      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
